// File: rtl/riscv_lsu_pkg.sv
// -----------------------------------------------------------------------------
// riscv_lsu_pkg
// Shared definitions for the RV32I load/store unit: data bus and byte-enable
// types, LSU FSM state encoding, LOAD/STORE funct3 encodings, and helpers for
// the accept-time fault check and store lane formatting.
// -----------------------------------------------------------------------------
package riscv_lsu_pkg;

    localparam int XLEN     = 32;
    localparam int REG_ADDR = 5;

    typedef logic [XLEN-1:0] dataBus_t;
    typedef logic [3:0]      byteEn_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } lsu_state_e;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } funct3_Type_LOAD;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } funct3_Type_STORE;

    // Encodings that name no RV32I load or store.
    function automatic logic lsu_illegal(input logic is_store, input logic [2:0] f3);
        logic bad;
        if (is_store) begin
            case (f3)
                SB, SH, SW: bad = 1'b0;
                default:    bad = 1'b1;
            endcase
        end else begin
            case (f3)
                LB, LH, LW, LBU, LHU: bad = 1'b0;
                default:              bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    // funct3[1:0] gives the access size for both loads and stores.
    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic byteEn_t store_be(input logic [2:0] f3, input logic [1:0] off);
        byteEn_t be;
        case (f3[1:0])
            2'b00:   be = byteEn_t'(4'b0001 << off);
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the store value into every lane so the byte enables alone
    // select which lanes memory writes.
    function automatic dataBus_t store_wdata(input logic [2:0] f3, input dataBus_t d);
        dataBus_t w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/riscv_load_align.sv
// -----------------------------------------------------------------------------
// riscv_load_align
// Combinational load formatter: shifts the addressed lane down to bit 0 and
// sign- or zero-extends it according to the load funct3.
//   rdata_i  [31:0] raw memory word
//   off_i    [1:0]  byte offset of the access within the word
//   funct3_i [2:0]  LOAD funct3
//   data_o   [31:0] extended load result
// -----------------------------------------------------------------------------
module riscv_load_align
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted_s;

    // Lane extraction and extension.
    always_comb begin
        shifted_s = rdata_i >> {off_i, 3'b000};
        case (funct3_i)
            LB:      data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            LH:      data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            LW:      data_o = shifted_s;
            LBU:     data_o = {24'h000000, shifted_s[7:0]};
            LHU:     data_o = {16'h0000, shifted_s[15:0]};
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// -----------------------------------------------------------------------------
// riscv_lsu
// Load/store unit between execute and the data-memory port. Takes one
// operation at a time, checks it for illegal funct3 / misalignment, issues a
// word-aligned byte-enabled request over req/gnt/rvalid and returns extended
// load data to writeback.
//   ex_*     operation from execute (valid/ready handshake, ready only in IDLE)
//   dmem_*   data-memory request and response
//   wb_*     load writeback (wb_valid_o is a one-cycle pulse)
//   fault_o  one-cycle pulse for a rejected operation
//   busy_o   high whenever an operation is in flight
// -----------------------------------------------------------------------------
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic                  ex_is_store_i,
    input  logic [2:0]            ex_funct3_i,
    input  logic [ADDR_WIDTH-1:0] ex_addr_i,
    input  logic [DATA_WIDTH-1:0] ex_wdata_i,
    input  logic [REG_ADDR-1:0]   ex_rd_i,

    output logic                  dmem_req_o,
    input  logic                  dmem_gnt_i,
    output logic                  dmem_we_o,
    output logic [3:0]            dmem_be_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,

    output logic                  wb_valid_o,
    output logic [REG_ADDR-1:0]   wb_rd_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,

    output logic                  fault_o,
    output logic                  busy_o
);

    lsu_state_e              state_q, state_d;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              off_q;
    logic [2:0]              funct3_q;
    logic [REG_ADDR-1:0]     rd_q;
    logic                    we_q;
    byteEn_t                 be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic                    wb_valid_q;
    logic [REG_ADDR-1:0]     wb_rd_q;
    logic [DATA_WIDTH-1:0]   wb_data_q;
    logic                    fault_q;

    logic                    accept_s;
    logic                    bad_s;
    logic                    start_s;
    logic                    rsp_s;
    logic [DATA_WIDTH-1:0]   load_data_s;

    // Accept-time decode: an operation in IDLE either starts or faults.
    always_comb begin
        accept_s = (state_q == IDLE) && ex_valid_i;
        bad_s    = lsu_illegal(ex_is_store_i, ex_funct3_i)
                 | lsu_misaligned(ex_funct3_i, ex_addr_i[1:0]);
        start_s  = accept_s && !bad_s;
        rsp_s    = (state_q == WAIT_RSP) && dmem_rvalid_i;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; gnt and rvalid only matter in their own states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    state_d = we_q ? IDLE : WAIT_RSP;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT_RSP: begin
                if (dmem_rvalid_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_RSP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs, decoded straight from the state register.
    always_comb begin
        ex_ready_o = 1'b0;
        dmem_req_o = 1'b0;
        busy_o     = 1'b0;
        case (state_q)
            IDLE:     ex_ready_o = 1'b1;
            REQ: begin
                dmem_req_o = 1'b1;
                busy_o     = 1'b1;
            end
            WAIT_RSP: busy_o = 1'b1;
            default: begin
                ex_ready_o = 1'b0;
                dmem_req_o = 1'b0;
                busy_o     = 1'b0;
            end
        endcase
    end

    // Latched operation; holds unchanged for the whole REQ phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= {ADDR_WIDTH{1'b0}};
            off_q    <= 2'b00;
            funct3_q <= 3'b000;
            rd_q     <= {REG_ADDR{1'b0}};
            we_q     <= 1'b0;
            be_q     <= 4'b0000;
            wdata_q  <= {DATA_WIDTH{1'b0}};
        end else if (start_s) begin
            addr_q   <= {ex_addr_i[ADDR_WIDTH-1:2], 2'b00};
            off_q    <= ex_addr_i[1:0];
            funct3_q <= ex_funct3_i;
            rd_q     <= ex_rd_i;
            we_q     <= ex_is_store_i;
            be_q     <= ex_is_store_i ? store_be(ex_funct3_i, ex_addr_i[1:0]) : 4'b1111;
            wdata_q  <= ex_is_store_i ? store_wdata(ex_funct3_i, ex_wdata_i)
                                      : {DATA_WIDTH{1'b0}};
        end
    end

    riscv_load_align u_align (
        .rdata_i  (dmem_rdata_i),
        .off_i    (off_q),
        .funct3_i (funct3_q),
        .data_o   (load_data_s)
    );

    // Writeback and fault pulses; wb data/rd hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= {REG_ADDR{1'b0}};
            wb_data_q  <= {DATA_WIDTH{1'b0}};
            fault_q    <= 1'b0;
        end else begin
            wb_valid_q <= rsp_s;
            fault_q    <= accept_s && bad_s;
            if (rsp_s) begin
                wb_rd_q   <= rd_q;
                wb_data_q <= load_data_s;
            end
        end
    end

    assign dmem_we_o    = we_q;
    assign dmem_be_o    = be_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign fault_o      = fault_q;

endmodule

// File: tb/tb_riscv_lsu.sv
module tb_riscv_lsu;
    import riscv_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid_i, ex_ready_o, ex_is_store_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_addr_i, ex_wdata_i;
    logic [4:0]  ex_rd_i;
    logic        dmem_req_o, dmem_gnt_i, dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        fault_o, busy_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    riscv_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_is_store_i(ex_is_store_i),
        .ex_funct3_i(ex_funct3_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i),
        .ex_rd_i(ex_rd_i),
        .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_we_o(dmem_we_o),
        .dmem_be_o(dmem_be_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .fault_o(fault_o), .busy_o(busy_o)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_wb;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd,
                                 input logic [31:0] rdata, input logic fault, input logic [3:0] be,
                                 input logic [31:0] exp_wdata, input logic [31:0] exp_addr,
                                 input logic [31:0] exp_wb);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rdata = rdata;
        v.fault = fault; v.be = be; v.exp_wdata = exp_wdata; v.exp_addr = exp_addr;
        v.exp_wb = exp_wb;
        return v;
    endfunction

    task automatic drive_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd);
        @(negedge clk);
        ex_valid_i = 1'b1; ex_is_store_i = st; ex_funct3_i = f3;
        ex_addr_i = addr; ex_wdata_i = wdata; ex_rd_i = rd;
        @(negedge clk);
        ex_valid_i = 1'b0;
    endtask

    // One operation with zero-stall memory; checks the fixed-latency timeline.
    task automatic run_vec(input vec_t v, input int i);
        drive_op(v.st, v.f3, v.addr, v.wdata, v.rd);
        if (v.fault) begin
            check($sformatf("v%0d_fault", i), {31'd0, fault_o}, 32'd1);
            check($sformatf("v%0d_noreq", i), {31'd0, dmem_req_o}, 32'd0);
            check($sformatf("v%0d_ready", i), {31'd0, ex_ready_o}, 32'd1);
            @(negedge clk);
            check($sformatf("v%0d_fault_pulse", i), {31'd0, fault_o}, 32'd0);
            check($sformatf("v%0d_noreq2", i), {31'd0, dmem_req_o}, 32'd0);
        end else begin
            check($sformatf("v%0d_nofault", i), {31'd0, fault_o}, 32'd0);
            check($sformatf("v%0d_req", i), {31'd0, dmem_req_o}, 32'd1);
            check($sformatf("v%0d_addr", i), dmem_addr_o, v.exp_addr);
            check($sformatf("v%0d_be", i), {28'd0, dmem_be_o}, {28'd0, v.be});
            check($sformatf("v%0d_we", i), {31'd0, dmem_we_o}, {31'd0, v.st});
            if (v.st) begin
                check($sformatf("v%0d_wdata", i), dmem_wdata_o, v.exp_wdata);
            end
            dmem_gnt_i = 1'b1;
            @(negedge clk);
            dmem_gnt_i = 1'b0;
            if (v.st) begin
                check($sformatf("v%0d_ready_after", i), {31'd0, ex_ready_o}, 32'd1);
                check($sformatf("v%0d_req_drop", i), {31'd0, dmem_req_o}, 32'd0);
            end else begin
                check($sformatf("v%0d_busy_wait", i), {31'd0, busy_o}, 32'd1);
                dmem_rvalid_i = 1'b1; dmem_rdata_i = v.rdata;
                @(negedge clk);
                dmem_rvalid_i = 1'b0;
                check($sformatf("v%0d_wbv", i), {31'd0, wb_valid_o}, 32'd1);
                check($sformatf("v%0d_wbdata", i), wb_data_o, v.exp_wb);
                check($sformatf("v%0d_wbrd", i), {27'd0, wb_rd_o}, {27'd0, v.rd});
                @(negedge clk);
                check($sformatf("v%0d_wbv_pulse", i), {31'd0, wb_valid_o}, 32'd0);
                check($sformatf("v%0d_wbdata_hold", i), wb_data_o, v.exp_wb);
            end
        end
    endtask

    initial begin
        int pulses;
        // st f3 addr wdata rd rdata fault be exp_wdata exp_addr exp_wb
        vecs[0]  = mkv(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h100, 32'h0);
        vecs[1]  = mkv(1'b1, 3'b000, 32'h103, 32'h000000AB, 5'd0, 32'h0, 1'b0, 4'b1000, 32'hABABABAB, 32'h100, 32'h0);
        vecs[2]  = mkv(1'b1, 3'b001, 32'h102, 32'h00001234, 5'd0, 32'h0, 1'b0, 4'b1100, 32'h12341234, 32'h100, 32'h0);
        vecs[3]  = mkv(1'b1, 3'b000, 32'h201, 32'h123456CD, 5'd0, 32'h0, 1'b0, 4'b0010, 32'hCDCDCDCD, 32'h200, 32'h0);
        vecs[4]  = mkv(1'b0, 3'b000, 32'h102, 32'h0, 5'd5, 32'h11802233, 1'b0, 4'b1111, 32'h0, 32'h100, 32'hFFFFFF80);
        vecs[5]  = mkv(1'b0, 3'b100, 32'h102, 32'h0, 5'd5, 32'h11802233, 1'b0, 4'b1111, 32'h0, 32'h100, 32'h00000080);
        vecs[6]  = mkv(1'b0, 3'b101, 32'h102, 32'h0, 5'd5, 32'h11802233, 1'b0, 4'b1111, 32'h0, 32'h100, 32'h00001180);
        vecs[7]  = mkv(1'b0, 3'b001, 32'h100, 32'h0, 5'd7, 32'h0000F00D, 1'b0, 4'b1111, 32'h0, 32'h100, 32'hFFFFF00D);
        vecs[8]  = mkv(1'b0, 3'b010, 32'h104, 32'h0, 5'd0, 32'hCAFEBABE, 1'b0, 4'b1111, 32'h0, 32'h104, 32'hCAFEBABE);
        vecs[9]  = mkv(1'b0, 3'b001, 32'h101, 32'h0, 5'd1, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0);
        vecs[10] = mkv(1'b0, 3'b010, 32'h102, 32'h0, 5'd1, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0);
        vecs[11] = mkv(1'b0, 3'b011, 32'h100, 32'h0, 5'd1, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0);
        vecs[12] = mkv(1'b1, 3'b010, 32'h102, 32'h1, 5'd0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0);
        vecs[13] = mkv(1'b1, 3'b100, 32'h100, 32'h1, 5'd0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0);
        vecs[14] = mkv(1'b1, 3'b001, 32'h101, 32'h1, 5'd0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0);

        rst_n = 1'b0; ex_valid_i = 1'b0; ex_is_store_i = 1'b0; ex_funct3_i = 3'b000;
        ex_addr_i = 32'h0; ex_wdata_i = 32'h0; ex_rd_i = 5'd0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        #12;
        check("rst_req", {31'd0, dmem_req_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_wbv", {31'd0, wb_valid_o}, 32'd0);
        check("rst_fault", {31'd0, fault_o}, 32'd0);
        check("rst_ready", {31'd0, ex_ready_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], i);
        end

        // Spurious rvalid in IDLE is ignored.
        @(negedge clk);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678;
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        check("spurious_wbv", {31'd0, wb_valid_o}, 32'd0);

        // Load with grant withheld three cycles, rvalid two cycles after grant.
        drive_op(1'b0, 3'b010, 32'h108, 32'h0, 5'd3);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall%0d_req", c), {31'd0, dmem_req_o}, 32'd1);
            check($sformatf("stall%0d_addr", c), dmem_addr_o, 32'h108);
            check($sformatf("stall%0d_be", c), {28'd0, dmem_be_o}, 32'hF);
            check($sformatf("stall%0d_busy", c), {31'd0, busy_o}, 32'd1);
            check($sformatf("stall%0d_ready", c), {31'd0, ex_ready_o}, 32'd0);
            @(negedge clk);
        end
        dmem_gnt_i = 1'b1;
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        check("stall_wait_busy", {31'd0, busy_o}, 32'd1);
        check("stall_wait_req", {31'd0, dmem_req_o}, 32'd0);
        @(negedge clk);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h55AA55AA;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            dmem_rvalid_i = 1'b0;
            if (wb_valid_o) pulses++;
        end
        check("stall_pulses", pulses, 32'd1);
        check("stall_wbdata", wb_data_o, 32'h55AA55AA);
        check("stall_wbrd", {27'd0, wb_rd_o}, 32'd3);

        // Reset during WAIT_RSP abandons the load; late response is ignored.
        drive_op(1'b0, 3'b010, 32'h10C, 32'h0, 5'd9);
        dmem_gnt_i = 1'b1;
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        check("arst_req", {31'd0, dmem_req_o}, 32'd0);
        check("arst_addr", dmem_addr_o, 32'h0);
        check("arst_be", {28'd0, dmem_be_o}, 32'h0);
        check("arst_wbdata", wb_data_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBAD0BAD0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            dmem_rvalid_i = 1'b0;
            if (wb_valid_o) pulses++;
        end
        check("arst_no_wb", pulses, 32'd0);
        run_vec(mkv(1'b0, 3'b010, 32'h110, 32'h0, 5'd4, 32'h0F0F1234, 1'b0, 4'b1111,
                    32'h0, 32'h110, 32'h0F0F1234), 99);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit sitting between the execute stage and the data-memory port of the RV32I core.
- Accepts one memory operation at a time from execute: ALU-computed address, rs2 store data, funct3, destination register.
- Generates aligned byte-enabled memory requests over a req/gnt/rvalid handshake.
- Returns sign- or zero-extended load data to writeback and flags misaligned or illegal accesses.

Parameters:
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- ex_valid_i  in  1  execute presents a memory operation.
- ex_ready_o  out  1  LSU can accept; high only in IDLE.
- ex_is_store_i  in  1  1 = store, 0 = load.
- ex_funct3_i  in  3  funct3_Type_LOAD / funct3_Type_STORE encoding.
- ex_addr_i  in  ADDR_WIDTH  effective byte address.
- ex_wdata_i  in  DATA_WIDTH  store data (rs2).
- ex_rd_i  in  REG_ADDR  load destination register.
- dmem_req_o  out  1  memory request.
- dmem_gnt_i  in  1  request accepted.
- dmem_we_o  out  1  write enable.
- dmem_be_o  out  4  byte enables.
- dmem_addr_o  out  ADDR_WIDTH  word-aligned address; bits [1:0] are always 0.
- dmem_wdata_o  out  DATA_WIDTH  lane-replicated store data.
- dmem_rvalid_i  in  1  load data valid.
- dmem_rdata_i  in  DATA_WIDTH  load data word.
- wb_valid_o  out  1  one-cycle pulse: load result valid.
- wb_rd_o  out  REG_ADDR  load destination.
- wb_data_o  out  DATA_WIDTH  extended load result.
- fault_o  out  1  one-cycle pulse: misaligned or illegal funct3.
- busy_o  out  1  high whenever not IDLE.

Behaviour:
- FSM states and outputs:
  - IDLE: ex_ready_o = 1.
  - REQ: dmem_req_o = 1.
  - WAIT_RSP: awaiting dmem_rvalid_i.
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - All dmem_* outputs, wb_*, fault_o and busy_o go to 0.
  - Latched operation registers are cleared.
- Accept: in IDLE with ex_valid_i = 1, the operation is checked in the same cycle.
- Fault check:
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - Misaligned: LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0.
  - On fault: fault_o pulses on the next cycle, no memory request is issued, state stays IDLE.
- Valid operation: address, funct3, rd, byte enables and formatted wdata are latched; next state is REQ.
- Store formatting:
  - SB: be = 1 << addr[1:0]; wdata = byte replicated 4 times.
  - SH: be = addr[1] ? 1100 : 0011; wdata = halfword replicated twice.
  - SW: be = 1111.
- Loads always issue be = 1111 and dmem_we_o = 0.
- REQ:
  - dmem_req_o and all request fields are held stable until dmem_gnt_i = 1.
  - On grant: a store goes to IDLE (complete, no writeback); a load goes to WAIT_RSP.
- Memory contract: dmem_rvalid_i arrives no earlier than the cycle after grant, exactly once per load grant.
- WAIT_RSP on dmem_rvalid_i:
  - Extract lane: rdata >> (8*addr[1:0]).
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - wb_data_o and wb_rd_o are registered; wb_valid_o pulses one cycle later.
  - State returns to IDLE.
- Latency with no stalls (gnt in first REQ cycle, rvalid next cycle):
  - Load: accept at cycle 0, req at cycle 1, rvalid at cycle 2, wb_valid_o at cycle 3.
  - Store: complete at cycle 1.
  - Throughput: one operation per 2 cycles (store) or 3 cycles (load).
- Loads to x0 perform the access and pulse wb_valid_o with rd = 0; the regfile discards the write.
- dmem_rvalid_i in IDLE or REQ (spurious or stale) is ignored; dmem_gnt_i outside REQ is ignored.
- Reset asserted during REQ or WAIT_RSP abandons the operation. A response arriving after reset is ignored and does not produce wb_valid_o.
- wb_data_o holds its last value between pulses. fault_o and wb_valid_o are never asserted together.

Decomposition:
- riscv_definitions additions:
  - lsu_state_e {IDLE, REQ, WAIT_RSP}.
  - byteEn_t (logic [3:0]).
- The existing funct3_Type_LOAD, funct3_Type_STORE, dataBus_t and REG_ADDR are reused.
- One combinational sub-module, riscv_load_align: inputs rdata, addr[1:0], funct3; output is the extended 32-bit result.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt immediate -> dmem_addr 0x100, be 1111, we 1, wdata 0xDEADBEEF; ex_ready_o high again at cycle 2.
- SB addr 0x103, data 0x000000AB -> dmem_addr 0x100, be 1000, wdata 0xABABABAB; SH addr 0x102, data 0x1234 -> be 1100, wdata 0x12341234.
- LB addr 0x102, rd 5, rdata 0x11802233 -> wb_data 0xFFFFFF80, wb_rd 5. Repeat as LBU -> 0x00000080; LHU addr 0x102 -> 0x00001180.
- LH addr 0x101 and LW addr 0x102 -> fault_o pulse, dmem_req_o stays 0, ex_ready_o remains 1. Load funct3 011 -> fault_o pulse.
- Load with gnt withheld 3 cycles, then rvalid 2 cycles after gnt:
  - req, addr and be are stable throughout; busy_o = 1 and ex_ready_o = 0.
  - Exactly one wb_valid_o pulse.
- rst_n low during WAIT_RSP, then rvalid after release -> all outputs 0 immediately, no wb_valid_o, next LW completes normally.
